// File: rtl/decision_level_stack_if.sv
// Decider / trail-unit facing signals of the decision level stack.
// Handshake: push and backtrack_req are single-cycle requests sampled on the rising clock edge; bt_valid and push_err are one-cycle result pulses.
interface decision_level_stack_if #(
    parameter int MAX_VARS   = 64,
    parameter int VAR_BITS   = $clog2(MAX_VARS),
    parameter int TRAIL_BITS = $clog2(MAX_VARS) + 1,
    parameter int LVL_BITS   = $clog2(MAX_VARS + 1)
);
    logic                  push;
    logic [VAR_BITS-1:0]   push_var;
    logic                  push_val;
    logic [TRAIL_BITS-1:0] push_trail;
    logic                  backtrack_req;
    logic                  busy;
    logic                  bt_valid;
    logic [VAR_BITS-1:0]   bt_var;
    logic                  bt_val;
    logic [TRAIL_BITS-1:0] bt_trail;
    logic                  unsat;
    logic [LVL_BITS-1:0]   level;
    logic [VAR_BITS-1:0]   top_var;
    logic                  top_flipped;
    logic                  empty;
    logic                  full;
    logic                  push_err;
    logic [1:0]            dbg_state;

    modport master (
        output push, push_var, push_val, push_trail, backtrack_req,
        input  busy, bt_valid, bt_var, bt_val, bt_trail, unsat, level,
               top_var, top_flipped, empty, full, push_err, dbg_state
    );

    modport slave (
        input  push, push_var, push_val, push_trail, backtrack_req,
        output busy, bt_valid, bt_var, bt_val, bt_trail, unsat, level,
               top_var, top_flipped, empty, full, push_err, dbg_state
    );
endinterface

// File: rtl/decision_level_stack.sv
// Decision stack with hardware chronological backtrack for the DPLL/CDCL control path.
// Flipped levels are popped one per cycle; the newest unflipped decision is flipped in place.
module decision_level_stack #(
    parameter int MAX_VARS   = 64,
    parameter int VAR_BITS   = $clog2(MAX_VARS),
    parameter int TRAIL_BITS = $clog2(MAX_VARS) + 1,
    parameter int LVL_BITS   = $clog2(MAX_VARS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    decision_level_stack_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_UNSAT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [VAR_BITS-1:0]   r_var   [MAX_VARS];
    logic                  r_val   [MAX_VARS];
    logic                  r_flip  [MAX_VARS];
    logic [TRAIL_BITS-1:0] r_trail [MAX_VARS];

    logic [LVL_BITS-1:0]   r_level;
    logic                  r_bt_valid;
    logic [VAR_BITS-1:0]   r_bt_var;
    logic                  r_bt_val;
    logic [TRAIL_BITS-1:0] r_bt_trail;
    logic                  r_push_err;

    logic                  w_empty;
    logic                  w_full;
    logic [VAR_BITS-1:0]   w_top_idx;
    logic [VAR_BITS-1:0]   w_wr_idx;
    logic                  w_do_push;
    logic                  w_do_pop;
    logic                  w_do_flip;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LVL_BITS'(MAX_VARS));
    assign w_top_idx = VAR_BITS'(r_level - LVL_BITS'(1));
    assign w_wr_idx  = VAR_BITS'(r_level);

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // A backtrack request wins over a same-cycle push; the push is reported as dropped.
    always_comb begin
        w_next_state = r_state;
        w_do_push    = 1'b0;
        w_do_pop     = 1'b0;
        w_do_flip    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.backtrack_req)          w_next_state = ST_SCAN;
                else if (bus.push && !w_full)   w_do_push    = 1'b1;
            end
            ST_SCAN: begin
                if (w_empty) begin
                    w_next_state = ST_UNSAT;
                end else if (r_flip[w_top_idx]) begin
                    w_do_pop = 1'b1;
                end else begin
                    w_do_flip    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_UNSAT: w_next_state = ST_UNSAT;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Entry storage is deliberately left unreset; only the level pointer defines validity.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_do_push) begin
                r_var[w_wr_idx]   <= bus.push_var;
                r_val[w_wr_idx]   <= bus.push_val;
                r_flip[w_wr_idx]  <= 1'b0;
                r_trail[w_wr_idx] <= bus.push_trail;
            end
            if (w_do_flip) begin
                r_val[w_top_idx]  <= ~r_val[w_top_idx];
                r_flip[w_top_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level    <= '0;
            r_bt_valid <= 1'b0;
            r_bt_var   <= '0;
            r_bt_val   <= 1'b0;
            r_bt_trail <= '0;
            r_push_err <= 1'b0;
        end else begin
            if (w_do_push)     r_level <= r_level + LVL_BITS'(1);
            else if (w_do_pop) r_level <= r_level - LVL_BITS'(1);
            r_bt_valid <= w_do_flip;
            if (w_do_flip) begin
                r_bt_var   <= r_var[w_top_idx];
                r_bt_val   <= ~r_val[w_top_idx];
                r_bt_trail <= r_trail[w_top_idx];
            end
            r_push_err <= bus.push && (w_full || (r_state != ST_IDLE) || bus.backtrack_req);
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.unsat       = (r_state == ST_UNSAT);
    assign bus.bt_valid    = r_bt_valid;
    assign bus.bt_var      = r_bt_var;
    assign bus.bt_val      = r_bt_val;
    assign bus.bt_trail    = r_bt_trail;
    assign bus.level       = r_level;
    assign bus.top_var     = w_empty ? '0 : r_var[w_top_idx];
    assign bus.top_flipped = w_empty ? 1'b0 : r_flip[w_top_idx];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.push_err    = r_push_err;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_decision_level_stack.sv
// Bench for decision_level_stack: directed scenarios then random push/backtrack traffic
// compared against a queue-based model of the decision stack.
module tb_decision_level_stack;
    localparam int MV  = 16;
    localparam int VB  = $clog2(MV);
    localparam int TBW = $clog2(MV) + 1;
    localparam int LB  = $clog2(MV + 1);

    typedef struct packed {
        logic [VB-1:0]  v;
        logic           val;
        logic           f;
        logic [TBW-1:0] t;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ent_t stk[$];
    bit   unsat_m = 1'b0;

    decision_level_stack_if #(.MAX_VARS(MV)) bus ();

    decision_level_stack #(.MAX_VARS(MV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.push          = 1'b0;
        bus.push_var      = '0;
        bus.push_val      = 1'b0;
        bus.push_trail    = '0;
        bus.backtrack_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        stk.delete();
        unsat_m = 1'b0;
    endtask

    task automatic do_push(input logic [VB-1:0] v, input logic val, input logic [TBW-1:0] t);
        ent_t e;
        bit   exp_err;
        bus.push       = 1'b1;
        bus.push_var   = v;
        bus.push_val   = val;
        bus.push_trail = t;
        tick();
        clear_inputs();
        exp_err = (stk.size() == MV) || unsat_m;
        check("push_err", bus.push_err, exp_err);
        if (!exp_err) begin
            e.v = v; e.val = val; e.f = 1'b0; e.t = t;
            stk.push_back(e);
        end
        check("level", bus.level, stk.size());
        check("top_var", bus.top_var, (stk.size() > 0) ? stk[stk.size()-1].v : '0);
        check("full", bus.full, stk.size() == MV);
        check("empty", bus.empty, stk.size() == 0);
    endtask

    task automatic do_backtrack(input bit with_push);
        int   k;
        int   n;
        bit   exp_unsat;
        ent_t e;
        bus.backtrack_req = 1'b1;
        if (with_push) begin
            bus.push       = 1'b1;
            bus.push_var   = VB'($urandom_range(0, MV - 1));
            bus.push_val   = 1'($urandom_range(0, 1));
            bus.push_trail = TBW'($urandom_range(0, 2 * MV - 1));
        end
        tick();
        clear_inputs();
        if (with_push) check("push_err_req", bus.push_err, 1);
        k = 0;
        while (stk.size() > 0 && stk[stk.size()-1].f) begin
            void'(stk.pop_back());
            k++;
        end
        exp_unsat = (stk.size() == 0);
        if (!exp_unsat) begin
            e = stk[stk.size()-1];
            e.val = ~e.val;
            e.f = 1'b1;
            stk[stk.size()-1] = e;
        end
        n = 1;
        while (!(bus.bt_valid || bus.unsat) && n < MV + 6) begin
            tick();
            n++;
        end
        check("bt_latency", n, k + 2);
        check("unsat", bus.unsat, exp_unsat);
        check("level_bt", bus.level, stk.size());
        if (exp_unsat) begin
            unsat_m = 1'b1;
            check("bt_valid_unsat", bus.bt_valid, 0);
            check("busy_unsat", bus.busy, 1);
        end else begin
            check("bt_valid", bus.bt_valid, 1);
            check("bt_var", bus.bt_var, e.v);
            check("bt_val", bus.bt_val, e.val);
            check("bt_trail", bus.bt_trail, e.t);
            check("top_flipped", bus.top_flipped, 1);
            check("top_var_bt", bus.top_var, e.v);
            check("busy_idle", bus.busy, 0);
            tick();
            check("bt_pulse", bus.bt_valid, 0);
        end
    endtask

    initial begin
        logic [VB-1:0] last_v;
        clear_inputs();
        do_reset();

        // Reset state.
        check("rst_level", bus.level, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_bt_valid", bus.bt_valid, 0);
        check("rst_unsat", bus.unsat, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_push_err", bus.push_err, 0);
        check("rst_top_var", bus.top_var, 0);
        check("rst_bt_var", bus.bt_var, 0);
        check("rst_bt_trail", bus.bt_trail, 0);

        // Worked example from the decision sequence (3,1,t0)(7,0,t2)(9,1,t5).
        do_push(VB'(3), 1'b1, TBW'(0));
        do_push(VB'(7), 1'b0, TBW'(2));
        do_push(VB'(9), 1'b1, TBW'(5));
        do_backtrack(1'b0);
        do_backtrack(1'b0);
        // Push racing a backtrack request is dropped.
        do_backtrack(1'b1);
        do_backtrack(1'b0);
        check("unsat_sticky", bus.unsat, 1);
        do_push(VB'(5), 1'b1, TBW'(1));
        tick();
        check("unsat_hold", bus.unsat, 1);

        // Reset while scanning aborts the backtrack.
        do_reset();
        for (int i = 0; i < 4; i++) do_push(VB'(i + 2), 1'b0, TBW'(i));
        bus.backtrack_req = 1'b1;
        tick();
        bus.backtrack_req = 1'b0;
        check("scan_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_level", bus.level, 0);
        check("abort_unsat", bus.unsat, 0);
        check("abort_bt_valid", bus.bt_valid, 0);
        tick();
        check("abort_bt_valid2", bus.bt_valid, 0);
        stk.delete();
        unsat_m = 1'b0;

        // Fill to capacity, then overflow.
        do_reset();
        last_v = '0;
        for (int i = 0; i < MV; i++) begin
            last_v = VB'($urandom_range(0, MV - 1));
            do_push(last_v, 1'($urandom_range(0, 1)), TBW'($urandom_range(0, 2 * MV - 1)));
        end
        check("full_set", bus.full, 1);
        do_push(last_v + VB'(1), 1'b1, TBW'(1));
        check("full_level", bus.level, MV);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            if (unsat_m) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6)
                    do_push(VB'($urandom_range(0, MV - 1)), 1'($urandom_range(0, 1)),
                            TBW'($urandom_range(0, 2 * MV - 1)));
                else
                    do_backtrack(r == 9);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
